fft_pipe_ctrl: RTL and testbench

Sequencer for one chain of NUM_STAGES negedge pipeline registers in the FFT datapath.
- Runs one frame of frame_len samples through the chain.
- Tracks a valid bit per stage.
- Drives a common stage enable (stall) and per-stage synchronous clears.
- Has ready/valid handshakes on input and output, and reports busy/done.

---
 rtl/fft_pipe_ctrl.sv | 115 +++++++++++
 tb/tb_fft_pipe_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_pipe_ctrl.sv
// Sequencer for one chain of NUM_STAGES pipeline registers: frame counting,
// per-stage valid tracking, common stall enable and synchronous stage clears.
module fft_pipe_ctrl #(
  parameter int NUM_STAGES = 4,
  parameter int CNT_W      = 11
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic [CNT_W-1:0]      frame_len,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [NUM_STAGES-1:0] stage_clr,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      out_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      len_q, len_d;
  logic [CNT_W-1:0]      in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]      out_cnt_q, out_cnt_d;
  logic [NUM_STAGES-1:0] valid_q, valid_d;
  logic                  done_q, done_d;

  logic advance;
  logic accept;
  logic out_hs;

  // Counters stop at the frame length so a stray handshake can never wrap them.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic [CNT_W-1:0] lim);
    return (cnt < lim) ? (cnt + CNT_W'(1)) : cnt;
  endfunction

  // A full last stage that is not being drained stalls the whole chain.
  assign advance   = ~(valid_q[NUM_STAGES-1] & ~out_ready);
  assign in_ready  = (state_q == S_RUN) & advance & (in_cnt_q < len_q);
  assign accept    = in_valid & in_ready;
  assign out_valid = valid_q[NUM_STAGES-1];
  assign out_hs    = out_valid & out_ready;
  assign stage_en  = {NUM_STAGES{advance}};
  assign stage_clr = {NUM_STAGES{clr | (state_q == S_FLUSH)}};
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign out_cnt   = out_cnt_q;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    valid_d   = valid_q;
    done_d    = 1'b0;

    if (advance) valid_d = {valid_q[NUM_STAGES-2:0], accept};
    if (accept)  in_cnt_d  = sat_inc(in_cnt_q, len_q);
    if (out_hs)  out_cnt_d = sat_inc(out_cnt_q, len_q);

    case (state_q)
      S_IDLE: begin
        if (start && (frame_len != '0)) begin
          state_d   = S_RUN;
          len_d     = frame_len;
          in_cnt_d  = '0;
          out_cnt_d = '0;
        end
      end
      S_RUN: begin
        if (flush)                              state_d = S_FLUSH;
        else if (accept && (in_cnt_d == len_q)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (flush) begin
          state_d = S_FLUSH;
        end else if (out_hs && (out_cnt_d == len_q)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      valid_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_fft_pipe_ctrl.sv
// Directed bench for fft_pipe_ctrl: per-cycle vector tables plus hand-written
// sequences for stall, flush, ignored starts and mid-frame reset.
module tb_fft_pipe_ctrl;
  localparam int N = 4;
  localparam int W = 11;

  logic         clk = 1'b0;
  logic         clr, start, flush, in_valid, out_ready;
  logic [W-1:0] frame_len;
  logic         in_ready, out_valid, busy, done;
  logic [N-1:0] stage_en, stage_clr;
  logic [W-1:0] out_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  fft_pipe_ctrl #(.NUM_STAGES(N), .CNT_W(W)) dut (
    .clk(clk), .clr(clr), .start(start), .frame_len(frame_len), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .stage_en(stage_en), .stage_clr(stage_clr),
    .busy(busy), .done(done), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         start;
    logic [W-1:0] len;
    logic         iv;
    logic         ordy;
    logic         e_ir;
    logic         e_ov;
    logic         e_busy;
    logic         e_done;
    logic [W-1:0] e_oc;
  } vec_t;

  localparam int NV = 29;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic s, input logic [W-1:0] l, input logic iv,
                              input logic ordy, input logic ir, input logic ov,
                              input logic b, input logic d, input logic [W-1:0] oc);
    vec_t v;
    v.start = s; v.len = l; v.iv = iv; v.ordy = ordy;
    v.e_ir = ir; v.e_ov = ov; v.e_busy = b; v.e_done = d; v.e_oc = oc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_done(input int maxc, output int hs, output bit seen);
    hs = 0;
    seen = 1'b0;
    for (int k = 0; k < maxc && !seen; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (out_valid && out_ready) hs++;
      if (done) seen = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, hs, dcnt, done_cyc, first_hs;
    bit seen;

    // Frame of 8, no stalls
    tbl[0]  = mk(1, 8, 1, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 8, 1, 1, 1, 0, 1, 0, 0);
    tbl[2]  = mk(0, 8, 1, 1, 1, 0, 1, 0, 0);
    tbl[3]  = mk(0, 8, 1, 1, 1, 0, 1, 0, 0);
    tbl[4]  = mk(0, 8, 1, 1, 1, 0, 1, 0, 0);
    tbl[5]  = mk(0, 8, 1, 1, 1, 1, 1, 0, 0);
    tbl[6]  = mk(0, 8, 1, 1, 1, 1, 1, 0, 1);
    tbl[7]  = mk(0, 8, 1, 1, 1, 1, 1, 0, 2);
    tbl[8]  = mk(0, 8, 1, 1, 1, 1, 1, 0, 3);
    tbl[9]  = mk(0, 8, 1, 1, 0, 1, 1, 0, 4);
    tbl[10] = mk(0, 8, 1, 1, 0, 1, 1, 0, 5);
    tbl[11] = mk(0, 8, 1, 1, 0, 1, 1, 0, 6);
    tbl[12] = mk(0, 8, 1, 1, 0, 1, 1, 0, 7);
    tbl[13] = mk(0, 8, 1, 1, 0, 0, 0, 1, 8);
    tbl[14] = mk(0, 8, 1, 1, 0, 0, 0, 0, 8);
    // Frame of 4 with alternating input bubbles
    tbl[15] = mk(1, 4, 0, 1, 0, 0, 0, 0, 8);
    tbl[16] = mk(0, 4, 1, 1, 1, 0, 1, 0, 0);
    tbl[17] = mk(0, 4, 0, 1, 1, 0, 1, 0, 0);
    tbl[18] = mk(0, 4, 1, 1, 1, 0, 1, 0, 0);
    tbl[19] = mk(0, 4, 0, 1, 1, 0, 1, 0, 0);
    tbl[20] = mk(0, 4, 1, 1, 1, 1, 1, 0, 0);
    tbl[21] = mk(0, 4, 0, 1, 1, 0, 1, 0, 1);
    tbl[22] = mk(0, 4, 1, 1, 1, 1, 1, 0, 1);
    tbl[23] = mk(0, 4, 0, 1, 0, 0, 1, 0, 2);
    tbl[24] = mk(0, 4, 0, 1, 0, 1, 1, 0, 2);
    tbl[25] = mk(0, 4, 0, 1, 0, 0, 1, 0, 3);
    tbl[26] = mk(0, 4, 0, 1, 0, 1, 1, 0, 3);
    tbl[27] = mk(0, 4, 0, 1, 0, 0, 0, 1, 4);
    tbl[28] = mk(0, 4, 0, 1, 0, 0, 0, 0, 4);

    clr = 1'b1; start = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    frame_len = '0;

    // Reset state
    @(negedge clk); #1;
    chk("rst stage_clr", 32'(stage_clr), 32'hF);
    chk("rst stage_en", 32'(stage_en), 32'hF);
    chk("rst in_ready", 32'(in_ready), 0);
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst out_cnt", 32'(out_cnt), 0);
    clr = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      start = tbl[i].start; frame_len = tbl[i].len;
      in_valid = tbl[i].iv; out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
      chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("row%0d done", i), 32'(done), 32'(tbl[i].e_done));
      chk($sformatf("row%0d out_cnt", i), 32'(out_cnt), 32'(tbl[i].e_oc));
      chk($sformatf("row%0d stage_en", i), 32'(stage_en), 32'hF);
      chk($sformatf("row%0d stage_clr", i), 32'(stage_clr), 0);
    end

    // Frame of 6 with a 3-cycle downstream stall while the last stage is full
    @(negedge clk);
    start = 1'b1; frame_len = 6; in_valid = 1'b1; out_ready = 1'b1;
    acc = 0; hs = 0; dcnt = 0; done_cyc = -1; first_hs = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      out_ready = !(c >= 5 && c <= 7);
      #1;
      if (c >= 5 && c <= 7) begin
        chk($sformatf("stall%0d stage_en", c), 32'(stage_en), 0);
        chk($sformatf("stall%0d in_ready", c), 32'(in_ready), 0);
        chk($sformatf("stall%0d out_valid", c), 32'(out_valid), 1);
      end
      if (in_valid && in_ready) acc++;
      if (out_valid && out_ready) begin
        hs++;
        if (first_hs < 0) first_hs = c;
      end
      if (done) begin
        dcnt++;
        if (done_cyc < 0) done_cyc = c;
      end
    end
    chk("stall accepts", 32'(acc), 6);
    chk("stall outputs", 32'(hs), 6);
    chk("stall first output cycle", 32'(first_hs), 8);
    chk("stall done pulses", 32'(dcnt), 1);
    chk("stall done cycle", 32'(done_cyc), 14);
    chk("stall out_cnt", 32'(out_cnt), 6);

    // Zero-length start and start during RUN are ignored
    @(negedge clk);
    start = 1'b1; frame_len = 0; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b1; frame_len = 3;
    #1;
    chk("len0 busy", 32'(busy), 0);
    chk("len0 in_ready", 32'(in_ready), 0);
    chk("len0 out_cnt held", 32'(out_cnt), 6);
    @(negedge clk);
    start = 1'b1; frame_len = 9;
    #1;
    chk("run busy", 32'(busy), 1);
    chk("run in_ready", 32'(in_ready), 1);
    chk("run out_cnt cleared", 32'(out_cnt), 0);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("restart ignored in_ready", 32'(in_ready), 0);
    chk("restart ignored busy", 32'(busy), 1);
    wait_done(30, hs, seen);
    chk("len3 done seen", 32'(seen), 1);
    chk("len3 outputs", 32'(hs), 3);
    chk("len3 out_cnt", 32'(out_cnt), 3);

    // Flush after 3 accepts of a 10-sample frame
    @(negedge clk);
    start = 1'b1; frame_len = 10; in_valid = 1'b1; out_ready = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b1;
    dcnt = 0;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush stage_clr", 32'(stage_clr), 32'hF);
    chk("flush busy", 32'(busy), 1);
    chk("flush in_ready", 32'(in_ready), 0);
    if (done) dcnt++;
    @(negedge clk);
    #1;
    chk("post-flush busy", 32'(busy), 0);
    chk("post-flush out_valid", 32'(out_valid), 0);
    chk("post-flush stage_clr", 32'(stage_clr), 0);
    chk("post-flush out_cnt", 32'(out_cnt), 0);
    if (done) dcnt++;
    @(negedge clk);
    flush = 1'b1;
    #1;
    if (done) dcnt++;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("idle flush busy", 32'(busy), 0);
    chk("idle flush stage_clr", 32'(stage_clr), 0);
    if (done) dcnt++;
    chk("flush done pulses", 32'(dcnt), 0);

    // Reset mid-DRAIN with two samples in flight, then a normal frame of 5
    @(negedge clk);
    start = 1'b1; frame_len = 5; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    clr = 1'b1;
    #1;
    chk("clr stage_clr", 32'(stage_clr), 32'hF);
    chk("pre-clr out_cnt", 32'(out_cnt), 3);
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("after clr in_ready", 32'(in_ready), 0);
    chk("after clr out_valid", 32'(out_valid), 0);
    chk("after clr busy", 32'(busy), 0);
    chk("after clr done", 32'(done), 0);
    chk("after clr out_cnt", 32'(out_cnt), 0);
    chk("after clr stage_en", 32'(stage_en), 32'hF);
    chk("after clr stage_clr", 32'(stage_clr), 0);
    @(negedge clk);
    start = 1'b1; frame_len = 5;
    wait_done(40, hs, seen);
    chk("len5 done seen", 32'(seen), 1);
    chk("len5 outputs", 32'(hs), 5);
    chk("len5 out_cnt", 32'(out_cnt), 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
